// File: rtl/fetch_stage.sv
// LC-3b instruction fetch stage: owns the PC, runs the I-cache read handshake and drives IF/ID.
// Optional one-entry skid buffer for responses blocked by a stall is enabled with `define FETCH_SKID_EN.
module fetch_stage #(
   parameter logic [15:0] PC_RESET = 16'h0000,
   parameter logic [15:0] NOP_WORD = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_read,
   output logic [15:0] mem_address,
   input  logic        mem_resp,
   input  logic [15:0] mem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] id_instruction,
   output logic [15:0] id_pc,
   output logic        id_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] drain_addr_q, drain_addr_d;
   logic [15:0] id_instruction_q, id_instruction_d;
   logic [15:0] id_pc_q, id_pc_d;
   logic        id_valid_q, id_valid_d;

   logic [15:0] pc_plus2;
   logic        slot_free;
   logic        skid_full;
   logic        accept_resp;
   logic        deliver_resp;

`ifdef FETCH_SKID_EN
   logic        skid_valid_q, skid_valid_d;
   logic [15:0] skid_instr_q, skid_instr_d;
   logic [15:0] skid_pc_q, skid_pc_d;
   logic        capture_skid;
   logic        skid_drain;

   assign skid_full = skid_valid_q;
`else
   assign skid_full = 1'b0;
`endif

   assign pc_plus2     = pc_q + 16'd2;
   assign slot_free    = !id_valid_q || !stall;
   // A response only counts when it answers a live, non-squashed FETCH request.
   assign accept_resp  = (state_q == FETCH) && !skid_full && mem_resp && !redirect;
   assign deliver_resp = accept_resp && slot_free;

`ifdef FETCH_SKID_EN
   assign capture_skid = accept_resp && !slot_free;
   assign skid_drain   = skid_full && slot_free && !redirect;
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   // NOTE: every sequential process uses non-blocking (<=) assignments so all
   // flops sample their _d values from the same pre-edge snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   // NOTE: each always_comb assigns a default to every output first, so no
   // path can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH: begin
            if (redirect && mem_read && !mem_resp) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_resp) begin
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs to the I-cache
   // ------------------------------------------------------------------
   always_comb begin
      mem_read    = 1'b0;
      mem_address = pc_q;
      case (state_q)
         FETCH: mem_read = !skid_full;
         DRAIN: begin
            mem_read    = 1'b1;
            mem_address = drain_addr_q;
         end
         default: mem_read = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: PC, drain address, IF/ID and skid next values
   // ------------------------------------------------------------------
   always_comb begin
      pc_d             = pc_q;
      drain_addr_d     = drain_addr_q;
      id_instruction_d = id_instruction_q;
      id_pc_d          = id_pc_q;
      id_valid_d       = id_valid_q;
`ifdef FETCH_SKID_EN
      skid_valid_d     = skid_valid_q;
      skid_instr_d     = skid_instr_q;
      skid_pc_d        = skid_pc_q;
`endif

      if (redirect) begin
         // Redirect beats stall: squash IF/ID and any parked word, keep the
         // outstanding address so the cache handshake can finish cleanly.
         pc_d             = redirect_pc;
         id_valid_d       = 1'b0;
         id_instruction_d = NOP_WORD;
`ifdef FETCH_SKID_EN
         skid_valid_d     = 1'b0;
`endif
         if ((state_q == FETCH) && mem_read && !mem_resp) begin
            drain_addr_d = pc_q;
         end
`ifdef FETCH_SKID_EN
      end else if (skid_drain) begin
         id_instruction_d = skid_instr_q;
         id_pc_d          = skid_pc_q;
         id_valid_d       = 1'b1;
         skid_valid_d     = 1'b0;
`endif
      end else if (deliver_resp) begin
         id_instruction_d = mem_rdata;
         id_pc_d          = pc_plus2;
         id_valid_d       = 1'b1;
         pc_d             = pc_plus2;
`ifdef FETCH_SKID_EN
      end else if (capture_skid) begin
         skid_instr_d     = mem_rdata;
         skid_pc_d        = pc_plus2;
         skid_valid_d     = 1'b1;
         pc_d             = pc_plus2;
`endif
      end else if (slot_free) begin
         id_valid_d       = 1'b0;
         id_instruction_d = NOP_WORD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q             <= PC_RESET;
         drain_addr_q     <= 16'h0000;
         id_instruction_q <= NOP_WORD;
         id_pc_q          <= 16'h0000;
         id_valid_q       <= 1'b0;
      end else begin
         pc_q             <= pc_d;
         drain_addr_q     <= drain_addr_d;
         id_instruction_q <= id_instruction_d;
         id_pc_q          <= id_pc_d;
         id_valid_q       <= id_valid_d;
      end
   end

`ifdef FETCH_SKID_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid_q <= 1'b0;
         skid_instr_q <= 16'h0000;
         skid_pc_q    <= 16'h0000;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end
`endif

   assign id_instruction = id_instruction_q;
   assign id_pc          = id_pc_q;
   assign id_valid       = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: I-cache model with variable latency feeding a scoreboard,
// plus directed timing checks; the skid-buffer behaviour is selected by FETCH_SKID_EN.
module tb_fetch_stage;

   localparam logic [15:0] PC_RESET = 16'h0000;
   localparam logic [15:0] NOP_WORD = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read;
   logic [15:0] mem_address;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] id_instruction;
   logic [15:0] id_pc;
   logic        id_valid;

   always #5 clk = ~clk;

   fetch_stage #(
      .PC_RESET(PC_RESET),
      .NOP_WORD(NOP_WORD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_read      (mem_read),
      .mem_address   (mem_address),
      .mem_resp      (mem_resp),
      .mem_rdata     (mem_rdata),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .id_instruction(id_instruction),
      .id_pc         (id_pc),
      .id_valid      (id_valid)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   entry_t exp_q[$];

   int checks     = 0;
   int errors     = 0;
   int deliveries = 0;
   int lat        = 1;
   logic mem_en   = 1'b1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] word_at(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   // All bench activity is phased after the rising edge: drive/check at +1,
   // cache model at +2, slot sampling at +3.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // I-cache model: answers after `lat` request cycles and predicts which
   // answered words must reach IF/ID (squashed and replayed ones excluded).
   initial begin : cache_model
      int          cnt;
      logic        discard_next;
      logic        have_last;
      logic [15:0] last_addr;
      logic        resp_now;
      logic [15:0] nxt;
      cnt = 0; discard_next = 1'b0; have_last = 1'b0; last_addr = 16'h0000;
      mem_resp  = 1'b0;
      mem_rdata = 16'hDEAD;
      forever begin
         @(posedge clk);
         #2;
         resp_now = 1'b0;
         if (!rst_n) begin
            cnt = 0;
            discard_next = 1'b0;
            have_last = 1'b0;
            exp_q.delete();
         end else if (mem_read && mem_en) begin
            if (cnt + 1 >= lat) begin
               resp_now = 1'b1;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else if (!mem_read) begin
            cnt = 0;
         end
         mem_resp  = resp_now;
         mem_rdata = resp_now ? word_at(mem_address) : 16'hDEAD;
         if (rst_n) begin
            if (resp_now && (redirect || discard_next)) begin
               discard_next = 1'b0;
            end else if (resp_now && !(have_last && last_addr == mem_address)) begin
               nxt = mem_address + 16'd2;
               exp_q.push_back('{instr: word_at(mem_address), pc: nxt});
               have_last = 1'b1;
               last_addr = mem_address;
            end
            if (redirect) begin
               exp_q.delete();
               have_last = 1'b0;
               if (mem_read && !resp_now) discard_next = 1'b1;
            end
         end
      end
   end

   // Scoreboard consumer: a new IF/ID word appears whenever the slot was free
   // before the edge and id_valid is high after it.
   initial begin : sb_monitor
      logic   sf_prev;
      entry_t e;
      sf_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && id_valid && sf_prev) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("sb_instr", 32'(id_instruction), 32'(e.instr));
               check("sb_pc", 32'(id_pc), 32'(e.pc));
               deliveries++;
            end
         end
         #2;
         sf_prev = rst_n && (!id_valid || !stall);
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not end by t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
      tick();
      tick();
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_instr", 32'(id_instruction), 32'(NOP_WORD));
      check("rst_id_pc", 32'(id_pc), 32'd0);

      // Straight-line fetch, single-cycle cache.
      rst_n = 1'b1;
      check("idle_mem_read", 32'(mem_read), 32'd0);
      tick();
      check("first_req", 32'({mem_read, mem_address}), 32'({1'b1, PC_RESET}));
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t1_valid", 32'(id_valid), 32'd1);
         check("t1_instr", 32'(id_instruction), 32'(word_at(16'(2 * k))));
         check("t1_pc", 32'(id_pc), 32'(16'(2 * k + 2)));
      end

      // Stall for three cycles with A1 in IF/ID.
      reset_dut();
      tick(); tick(); tick();
      check("t2_a1", 32'({id_instruction, id_pc}), {word_at(16'h0002), 16'h0004});
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_hold", 32'({id_valid, id_instruction, id_pc}) & 32'hFFFF_FFFF,
               {word_at(16'h0002), 16'h0004});
         check("t2_hold_valid", 32'(id_valid), 32'd1);
`ifdef FETCH_SKID_EN
         check("t2_skid_noreq", 32'(mem_read), 32'd0);
`else
         check("t2_replay_req", 32'({mem_read, mem_address}), 32'({1'b1, 16'h0004}));
`endif
      end
      stall = 1'b0;
      tick();
      check("t2_a2", 32'({id_instruction, id_pc}), {word_at(16'h0004), 16'h0006});
      check("t2_a2_valid", 32'(id_valid), 32'd1);
      check("t2_next_req", 32'({mem_read, mem_address}), 32'({1'b1, 16'h0006}));

      // Three-cycle cache, redirect while the 0x0008 request is outstanding.
      reset_dut();
      lat = 3;
      for (int i = 0; i < 100 && !(mem_read && mem_address == 16'h0008); i++) tick();
      check("t3_reach", 32'(mem_address), 32'h0008);
      tick();
      redirect = 1'b1; redirect_pc = 16'h0100;
      tick();
      redirect = 1'b0;
      check("t3_drain_req", 32'({mem_read, mem_address}), 32'({1'b1, 16'h0008}));
      check("t3_drain_valid", 32'(id_valid), 32'd0);
      tick();
      check("t3_new_req", 32'({mem_read, mem_address}), 32'({1'b1, 16'h0100}));
      check("t3_wait_valid0", 32'(id_valid), 32'd0);
      tick();
      check("t3_wait_valid1", 32'(id_valid), 32'd0);
      tick();
      check("t3_wait_valid2", 32'(id_valid), 32'd0);
      tick();
      check("t3_target", 32'({id_instruction, id_pc}), {word_at(16'h0100), 16'h0102});
      check("t3_target_valid", 32'(id_valid), 32'd1);

      // Redirect coincident with a cache response.
      lat = 1;
      tick();
      check("t4_pre_req", 32'(mem_read), 32'd1);
      redirect = 1'b1; redirect_pc = 16'h0200;
      tick();
      redirect = 1'b0;
      check("t4_bubble", 32'(id_valid), 32'd0);
      check("t4_new_req", 32'({mem_read, mem_address}), 32'({1'b1, 16'h0200}));
      tick();
      check("t4_target", 32'({id_instruction, id_pc}), {word_at(16'h0200), 16'h0202});
      check("t4_target_valid", 32'(id_valid), 32'd1);

      // Reset asserted while draining a squashed request.
      lat = 4;
      redirect = 1'b1; redirect_pc = 16'h0300;
      tick();
      redirect = 1'b0;
      check("t5_drain_req", 32'({mem_read, mem_address}), 32'({1'b1, 16'h0202}));
      rst_n = 1'b0;
      #1;
      check("t5_async_mem_read", 32'(mem_read), 32'd0);
      check("t5_async_valid", 32'(id_valid), 32'd0);
      check("t5_async_instr", 32'(id_instruction), 32'(NOP_WORD));
      tick();
      rst_n = 1'b1;
      check("t5_idle", 32'(mem_read), 32'd0);
      tick();
      check("t5_restart_req", 32'({mem_read, mem_address}), 32'({1'b1, PC_RESET}));

      // PC wrap-around at the top of memory.
      lat = 1;
      tick();
      redirect = 1'b1; redirect_pc = 16'hFFFC;
      tick();
      redirect = 1'b0;
      check("t6_req", 32'({mem_read, mem_address}), 32'({1'b1, 16'hFFFC}));
      tick();
      check("t6_pc_fffe", 32'({id_instruction, id_pc}), {word_at(16'hFFFC), 16'hFFFE});
      tick();
      check("t6_pc_wrap", 32'({id_instruction, id_pc}), {word_at(16'hFFFE), 16'h0000});
      tick();
      check("t6_pc_after", 32'({id_instruction, id_pc}), {word_at(16'h0000), 16'h0002});

      // Random stalls, redirects and latencies against the scoreboard.
      for (int i = 0; i < 300; i++) begin
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = 16'($urandom) & 16'hFFFE;
         if ($urandom_range(0, 31) == 0) lat = int'($urandom_range(1, 3));
         tick();
      end
      stall = 1'b0;
      redirect = 1'b0;
      repeat (6) tick();
      mem_en = 1'b0;
      repeat (3) tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      check("sb_activity", 32'(deliveries > 40), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the pipelined LC-3b, directly upstream of decode.
- Owns the PC and runs the read handshake to the L1 I-side cache port.
- Drives the IF/ID pipeline register (instruction, PC+2, valid) that decode consumes.
- Honours the downstream stall and branch/jump redirect; redirect squashes in-flight fetches.

Parameters:
- PC_RESET, 16'h0000, PC value fetched first after reset.
- NOP_WORD, 16'h0000, instruction presented on id_instruction while id_valid=0 (BR nzp=000).

Ports:
- clk  input  1  pipeline clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_read  output  1  I-cache read request; held with stable mem_address until mem_resp.
- mem_address  output  16  byte address of requested instruction word.
- mem_resp  input  1  one-cycle pulse; mem_rdata valid in the same cycle.
- mem_rdata  input  16  fetched instruction word.
- stall  input  1  decode/hazard unit cannot accept; IF/ID must hold.
- redirect  input  1  taken branch/JMP/JSR/TRAP from later stage; squash and refetch.
- redirect_pc  input  16  new fetch address, valid when redirect=1.
- id_instruction  output  16  IF/ID instruction to decode.
- id_pc  output  16  IF/ID incremented PC (fetch address + 2).
- id_valid  output  1  IF/ID holds a live instruction.

Behaviour:
- Reset (async, rst_n=0): pc=PC_RESET, state=IDLE, id_valid=0, id_instruction=NOP_WORD, id_pc=16'h0000, mem_read=0; skid cleared if present.
- States: IDLE, FETCH, DRAIN. mem_read=1 in FETCH (unless skid full) and in DRAIN; 0 in IDLE. mem_address=pc in FETCH; latched squashed address in DRAIN.
- IDLE -> FETCH unconditionally next cycle (first request one cycle after reset release).
- slot_free = !id_valid || !stall.
- FETCH, mem_resp=1, slot_free, no redirect: IF/ID <= {mem_rdata, pc+2, 1}; pc <= pc+2 (16-bit wrap, 16'hFFFE+2=16'h0000). Back-to-back: new request same address sequence next cycle.
- FETCH, mem_resp=1, !slot_free: response not accepted; pc unchanged, request re-issued next cycle (replay). IF/ID holds.
- stall=1 and id_valid=1: IF/ID registers hold value exactly.
- slot_free and no instruction delivered this cycle: id_valid <= 0, id_instruction <= NOP_WORD (bubble).
- redirect=1 (highest priority, overrides stall): pc <= redirect_pc; id_valid <= 0; skid invalidated.
  - mem_read=1 and mem_resp=0 that cycle: -> DRAIN, keep old request until mem_resp, discard data, -> FETCH with new pc.
  - mem_resp=1 same cycle: data discarded, stay/enter FETCH at redirect_pc next cycle.
  - redirect while in DRAIN: update pc only, stay in DRAIN.
- Latency: mem_resp edge to id_valid=1 is one cycle.
- Reset mid-operation (any state): immediate return to reset values; outstanding cache response after reset is ignored only if it arrives in IDLE.

Optional Feature:
- Macro FETCH_SKID_EN.
- Defined: one-entry skid buffer {instr, pc+2}. Response with !slot_free is captured in skid, pc <= pc+2, mem_read=0 while skid full. When slot_free, skid loads into IF/ID (priority over new responses; no new response can be pending), skid empties, fetching resumes next cycle.
- Undefined: no skid; blocked responses replayed as described.

Test Plan:
- Reset, 1-cycle cache latency, words A0..A3 at 0x0000..0x0006 -> id_instruction A0,A1,A2,A3 on consecutive cycles, id_pc 0x0002,0x0004,0x0006,0x0008, id_valid=1 throughout.
- stall=1 for 3 cycles with A1 in IF/ID, resp for 0x0004 during stall -> IF/ID stays A1/0x0004; without skid mem_address stays 0x0004 and is re-requested; A2 appears one cycle after resp following stall release.
- 3-cycle latency, redirect to 0x0100 one cycle after request to 0x0008 -> mem_address stays 0x0008 until resp, data dropped, next request 0x0100, id_valid=0 until 0x0100 data delivered with id_pc 0x0102.
- redirect to 0x0200 coincident with mem_resp -> data not loaded into IF/ID, next mem_address 0x0200, id_valid=0 one cycle.
- rst_n low mid-DRAIN -> mem_read=0, id_valid=0 immediately; after release IDLE one cycle then request PC_RESET.
- FETCH_SKID_EN: stall 3 cycles, resp for 0x0004 -> mem_read drops to 0 while stalled; stall release -> 0x0004 instruction in IF/ID next cycle, request 0x0006 issued that cycle.
